// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the core's load/store path and the data
// memory responder.
//   req_valid/req_ready : request handshake (core -> memory)
//   mem_read/mem_write  : request kind, qualified by req_valid
//   addr/wdata          : byte address and store data
//   rsp_valid           : one-cycle response pulse (memory -> core)
//   rdata/rsp_err       : load data and rejection flag, valid with rsp_valid
// Modports: master = core side, slave = memory side.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        rsp_valid;
  logic [15:0] rdata;
  logic        rsp_err;

  modport master (
    output req_valid, mem_read, mem_write, addr, wdata,
    input  req_ready, rsp_valid, rdata, rsp_err
  );

  modport slave (
    input  req_valid, mem_read, mem_write, addr, wdata,
    output req_ready, rsp_valid, rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed 16-bit data memory responding to the core's load/store
// requests. One request is accepted at a time, WAIT_CYCLES wait states are
// inserted, the access is performed and a one-cycle response is returned.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset (control and response registers)
//   bus   : slave side of data_mem_responder_if (request + response)
// Parameters:
//   ADDR_W      : word-address width, depth = 2**ADDR_W words
//   WAIT_CYCLES : wait states before each access, 0..15
module data_mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  data_mem_responder_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [3:0]          cnt;
  logic [3:0]          cnt_nxt;
  logic                accept;
  logic                access;

  logic [15:0]         addr_p0;
  logic [15:0]         wdata_p0;
  logic                rd_p0;
  logic                wr_p0;
  logic                err_p0;
  logic [ADDR_W-1:0]   index_p0;

  logic [15:0]         mem [DEPTH];

  // A request is rejected when misaligned, beyond the array, or when it is
  // not exactly one of load/store.
  function automatic logic req_err(input logic [15:0] a,
                                   input logic        rd,
                                   input logic        wr);
    logic [15:0] hi;
    hi = a >> (ADDR_W + 1);
    return a[0] | (hi != 16'd0) | (rd == wr);
  endfunction

  assign bus.req_ready = (state == IDLE);
  assign accept        = bus.req_valid && (state == IDLE);
  assign access        = (state == BUSY) && (cnt == 4'd0);
  assign index_p0      = addr_p0[ADDR_W:1];
  assign err_p0        = req_err(addr_p0, rd_p0, wr_p0);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = BUSY;
          cnt_nxt   = 4'(WAIT_CYCLES);
        end
      end
      BUSY: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Stage p0: request captured at accept, held through the wait states.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p0  <= bus.addr;
      wdata_p0 <= bus.wdata;
      rd_p0    <= bus.mem_read;
      wr_p0    <= bus.mem_write;
    end
  end

  // Stage p1: access edge. Storage write and registered response share it,
  // so a load accepted after a store always sees the stored value.
  always_ff @(posedge clk) begin
    if (access && !err_p0 && wr_p0) begin
      mem[index_p0] <= wdata_p0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_valid <= 1'b0;
      bus.rdata     <= 16'h0000;
      bus.rsp_err   <= 1'b0;
    end else begin
      bus.rsp_valid <= access;
      if (access) begin
        bus.rdata   <= (err_p0 || wr_p0) ? 16'h0000 : mem[index_p0];
        bus.rsp_err <= err_p0;
      end
    end
  end

endmodule
